// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types, constants and helpers for the binary32 FPU
package pa_fpu;

  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1,
    op_mul = 2'd2,
    op_div = 2'd3
  } e_fpu_op;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_UNPACK     = 3'd1,
    ST_CALC       = 3'd2,
    ST_NORM_ROUND = 3'd3,
    ST_DONE       = 3'd4
  } e_fpu_state;

  localparam logic [31:0]        QNAN     = 32'h7FC0_0000;
  localparam logic signed [11:0] EXP_BIAS = 12'sd127;
  localparam logic [7:0]         EXP_MAX  = 8'hFF;

  // Leading-zero count of a 24-bit significand; 24 when the input is zero.
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) lzc24 = 5'(23 - i);
    end
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - normalize, denormalize, RNE round and pack a binary32 result
// Value presented is (i_sig / 2^46) * 2^(i_exp - 127), plus i_sticky below bit 0.
module fpu_round_pack
  import pa_fpu::*;
(
  input  logic               i_sign,
  input  logic signed [11:0] i_exp,
  input  logic [47:0]        i_sig,
  input  logic               i_sticky,
  output logic [31:0]        o_result
);

  logic [5:0]         w_lz;
  logic signed [11:0] w_sh;
  logic signed [11:0] w_exp_n;
  logic signed [11:0] w_exp_f;
  logic [11:0]        w_rs;
  logic [46:0]        w_norm;
  logic               w_st;
  logic               w_inc;
  logic               w_hidden;
  logic [24:0]        w_m25;
  logic [22:0]        w_frac;

  always_comb begin
    w_lz = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (i_sig[i]) w_lz = 6'(47 - i);
    end
    // Negative shift means right shift; clamp so the exponent never drops below 1.
    w_sh = $signed({6'd0, w_lz}) - 12'sd1;
    if (i_exp - w_sh < 12'sd1) w_sh = i_exp - 12'sd1;
    w_exp_n = i_exp - w_sh;
    w_rs    = 12'(-w_sh);
    w_st    = i_sticky;
    if (!w_sh[11]) begin
      w_norm = 47'(i_sig << w_sh[5:0]);
    end else if (w_rs >= 12'd48) begin
      w_norm = '0;
      w_st   = i_sticky | (|i_sig);
    end else begin
      w_norm = 47'(i_sig >> w_rs[5:0]);
      w_st   = i_sticky | (|(i_sig & ~({48{1'b1}} << w_rs[5:0])));
    end

    w_inc = w_norm[22] & (w_norm[21] | (|w_norm[20:0]) | w_st | w_norm[23]);
    w_m25 = {1'b0, w_norm[46:23]} + {24'd0, w_inc};
    if (w_m25[24]) begin
      w_exp_f  = w_exp_n + 12'sd1;
      w_frac   = w_m25[23:1];
      w_hidden = 1'b1;
    end else begin
      w_exp_f  = w_exp_n;
      w_frac   = w_m25[22:0];
      w_hidden = w_m25[23];
    end

    if (i_sig == '0 && !i_sticky) begin
      o_result = {i_sign, 31'd0};
    end else if (w_exp_f >= 12'sd255) begin
      o_result = {i_sign, EXP_MAX, 23'd0};
    end else begin
      o_result = {i_sign, (w_hidden ? w_exp_f[7:0] : 8'd0), w_frac};
    end
  end

endmodule

// File: rtl/fpu.sv
// rtl/fpu.sv - multi-cycle binary32 add/sub/mul/div unit with start/busy/cmd_end handshake
module fpu
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  e_fpu_op     operation,
  output logic [31:0] ieee_packet_out,
  output logic        cmd_end,
  output logic        busy
);

  e_fpu_state         r_state;
  e_fpu_op            r_op;
  logic [31:0]        r_a, r_b;
  logic [4:0]         r_cnt;
  logic               r_sign, r_eff_sub, r_sticky, r_special;
  logic [31:0]        r_special_val;
  logic signed [11:0] r_exp;
  logic [47:0]        r_acc, r_mcand;
  logic [23:0]        r_mplier;
  logic [25:0]        r_rem, r_q;

  logic               w_sa, w_sb, w_sp;
  logic [23:0]        w_ma, w_mb, w_na, w_nb, w_big_m, w_small_m;
  logic signed [11:0] w_ea, w_eb, w_ena, w_enb, w_big_e, w_small_e, w_d;
  logic [4:0]         w_lza, w_lzb;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic               w_a_big, w_al_st, w_special;
  logic [31:0]        w_special_val, w_rp_result;
  logic [47:0]        w_small_ext, w_small_al, w_rp_sig;
  logic               w_rem_ge, w_rp_sign, w_rp_sticky;
  logic [24:0]        w_rem_nx;

  assign w_sa     = r_a[31];
  assign w_sb     = r_b[31] ^ (r_op == op_sub);
  assign w_sp     = w_sa ^ w_sb;
  assign w_ma     = {|r_a[30:23], r_a[22:0]};
  assign w_mb     = {|r_b[30:23], r_b[22:0]};
  assign w_ea     = $signed({4'd0, (r_a[30:23] == 8'd0) ? 8'd1 : r_a[30:23]});
  assign w_eb     = $signed({4'd0, (r_b[30:23] == 8'd0) ? 8'd1 : r_b[30:23]});
  assign w_a_nan  = (&r_a[30:23]) & (|r_a[22:0]);
  assign w_b_nan  = (&r_b[30:23]) & (|r_b[22:0]);
  assign w_a_inf  = (&r_a[30:23]) & ~(|r_a[22:0]);
  assign w_b_inf  = (&r_b[30:23]) & ~(|r_b[22:0]);
  assign w_a_zero = ~(|r_a[30:0]);
  assign w_b_zero = ~(|r_b[30:0]);

  // Mul/div work on normalized significands so subnormal operands keep full precision.
  assign w_lza = lzc24(w_ma);
  assign w_lzb = lzc24(w_mb);
  assign w_na  = w_ma << w_lza;
  assign w_nb  = w_mb << w_lzb;
  assign w_ena = w_ea - $signed({7'd0, w_lza});
  assign w_enb = w_eb - $signed({7'd0, w_lzb});

  assign w_a_big   = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
  assign w_big_m   = w_a_big ? w_ma : w_mb;
  assign w_small_m = w_a_big ? w_mb : w_ma;
  assign w_big_e   = w_a_big ? w_ea : w_eb;
  assign w_small_e = w_a_big ? w_eb : w_ea;
  assign w_d       = w_big_e - w_small_e;
  assign w_small_ext = {1'b0, w_small_m, 23'd0};

  always_comb begin
    w_small_al = '0;
    w_al_st    = |w_small_m;
    if (w_d < 12'sd26) begin
      w_small_al = w_small_ext >> w_d[4:0];
      w_al_st    = |(w_small_ext & ~({48{1'b1}} << w_d[4:0]));
    end
  end

  always_comb begin
    w_special     = 1'b1;
    w_special_val = QNAN;
    case (r_op)
      op_mul: begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) w_special_val = QNAN;
        else if (w_a_inf || w_b_inf) w_special_val = {w_sp, EXP_MAX, 23'd0};
        else w_special = 1'b0;
      end
      op_div: begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) w_special_val = QNAN;
        else if (w_b_zero || w_a_inf) w_special_val = {w_sp, EXP_MAX, 23'd0};
        else if (w_b_inf || w_a_zero) w_special_val = {w_sp, 31'd0};
        else w_special = 1'b0;
      end
      default: begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) w_special_val = QNAN;
        else if (w_a_inf) w_special_val = {w_sa, EXP_MAX, 23'd0};
        else if (w_b_inf) w_special_val = {w_sb, EXP_MAX, 23'd0};
        else w_special = 1'b0;
      end
    endcase
  end

  assign w_rem_ge = (r_rem >= {2'd0, r_mplier});
  assign w_rem_nx = 25'(w_rem_ge ? r_rem - {2'd0, r_mplier} : r_rem);

  // An exact cancellation yields +0; same-sign zeros keep their sign.
  assign w_rp_sign   = (r_eff_sub && r_acc == '0 && !r_sticky) ? 1'b0 : r_sign;
  assign w_rp_sig    = (r_op == op_div) ? {1'b0, r_q, 21'd0} : r_acc;
  assign w_rp_sticky = (r_op == op_div) ? (|r_rem) : r_sticky;

  fpu_round_pack u_round_pack (
    .i_sign   (w_rp_sign),
    .i_exp    (r_exp),
    .i_sig    (w_rp_sig),
    .i_sticky (w_rp_sticky),
    .o_result (w_rp_result)
  );

  assign busy    = (r_state != ST_IDLE);
  assign cmd_end = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state         <= ST_IDLE;
      r_op            <= op_add;
      r_a             <= '0;
      r_b             <= '0;
      r_cnt           <= '0;
      r_sign          <= 1'b0;
      r_eff_sub       <= 1'b0;
      r_sticky        <= 1'b0;
      r_special       <= 1'b0;
      r_special_val   <= '0;
      r_exp           <= '0;
      r_acc           <= '0;
      r_mcand         <= '0;
      r_mplier        <= '0;
      r_rem           <= '0;
      r_q             <= '0;
      ieee_packet_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a_operand;
            r_b     <= b_operand;
            r_op    <= operation;
            r_state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_q           <= '0;
          r_rem         <= {2'd0, w_na};
          r_mplier      <= w_nb;
          r_sticky      <= 1'b0;
          r_eff_sub     <= 1'b0;
          r_state       <= ST_CALC;
          case (r_op)
            op_mul: begin
              r_sign  <= w_sp;
              r_exp   <= w_ena + w_enb - EXP_BIAS;
              r_acc   <= '0;
              r_mcand <= {24'd0, w_na};
              r_cnt   <= 5'd23;
            end
            op_div: begin
              r_sign  <= w_sp;
              r_exp   <= w_ena - w_enb + EXP_BIAS;
              r_acc   <= '0;
              r_mcand <= '0;
              r_cnt   <= 5'd25;
            end
            default: begin
              r_sign    <= w_a_big ? w_sa : w_sb;
              r_exp     <= w_big_e;
              r_acc     <= {1'b0, w_big_m, 23'd0};
              r_mcand   <= w_small_al;
              r_sticky  <= w_al_st;
              r_eff_sub <= (w_sa != w_sb);
              r_cnt     <= 5'd0;
            end
          endcase
        end
        ST_CALC: begin
          case (r_op)
            op_mul: begin
              if (r_mplier[0]) r_acc <= r_acc + r_mcand;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
            end
            op_div: begin
              r_rem <= {w_rem_nx, 1'b0};
              r_q   <= {r_q[24:0], w_rem_ge};
            end
            default: begin
              // Borrowing the sticky keeps the truncated difference exact below bit 0.
              r_acc <= r_eff_sub ? (r_acc - r_mcand - {47'd0, r_sticky}) : (r_acc + r_mcand);
            end
          endcase
          if (r_cnt == 5'd0) r_state <= ST_NORM_ROUND;
          else r_cnt <= r_cnt - 5'd1;
        end
        ST_NORM_ROUND: begin
          ieee_packet_out <= r_special ? r_special_val : w_rp_result;
          r_state         <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu.sv
// tb/tb_fpu.sv - directed-vector self-checking bench for the binary32 FPU
module tb_fpu;
  import pa_fpu::*;

  logic        clk;
  logic        arst;
  logic        start;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  e_fpu_op     operation;
  logic [31:0] ieee_packet_out;
  logic        cmd_end;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    e_fpu_op     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [] = '{
    '{op_add, 32'h3F800000, 32'h3F8CCCCD, 32'h40066666},
    '{op_sub, 32'h41800000, 32'h42000000, 32'hC1800000},
    '{op_mul, 32'h41800000, 32'h42000000, 32'h44000000},
    '{op_div, 32'h3E800000, 32'h3F000000, 32'h3F000000},
    '{op_add, 32'h00000001, 32'h00000001, 32'h00000002},
    '{op_sub, 32'h00800000, 32'h00400000, 32'h00400000},
    '{op_sub, 32'h00000001, 32'h00000001, 32'h00000000},
    '{op_sub, 32'h7F800000, 32'h7F800000, 32'h7FC00000},
    '{op_div, 32'h3F800000, 32'h00000000, 32'h7F800000},
    '{op_mul, 32'h42168F5C, 32'h00000000, 32'h00000000},
    '{op_add, 32'h7FC00000, 32'h402DF854, 32'h7FC00000},
    '{op_mul, 32'h00000001, 32'h7F800000, 32'h7F800000},
    '{op_div, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB},
    '{op_mul, 32'h7F000000, 32'h40000000, 32'h7F800000},
    '{op_mul, 32'h00800000, 32'h3F000000, 32'h00400000},
    '{op_div, 32'hBF800000, 32'h7F800000, 32'h80000000},
    '{op_add, 32'h80000000, 32'h80000000, 32'h80000000},
    '{op_add, 32'h3F800000, 32'hBF800000, 32'h00000000},
    '{op_add, 32'h3F800001, 32'h3F800000, 32'h40000000},
    '{op_add, 32'h3F800003, 32'h3F800000, 32'h40000002},
    '{op_add, 32'h3F800000, 32'h33000000, 32'h3F800000},
    '{op_add, 32'h3F800000, 32'h33800001, 32'h3F800001},
    '{op_sub, 32'h3F800000, 32'h33800001, 32'h3F7FFFFF}
  };

  fpu dut (
    .clk             (clk),
    .arst            (arst),
    .start           (start),
    .a_operand       (a_operand),
    .b_operand       (b_operand),
    .operation       (operation),
    .ieee_packet_out (ieee_packet_out),
    .cmd_end         (cmd_end),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input string tag, input e_fpu_op op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res);
    int lat;
    int max_lat;
    bit seen;
    max_lat = (op == op_mul) ? 30 : (op == op_div) ? 32 : 8;
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    operation = op;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
    operation = op_add;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (cmd_end) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("%s_done", tag), {31'd0, seen}, 32'd1);
    chk($sformatf("%s_lat_ok", tag), {31'd0, (lat <= max_lat)}, 32'd1);
    chk($sformatf("%s_busy_done", tag), {31'd0, busy}, 32'd1);
    chk($sformatf("%s_result", tag), ieee_packet_out, exp_res);
    @(negedge clk);
    chk($sformatf("%s_pulse_end", tag), {31'd0, cmd_end}, 32'd0);
    chk($sformatf("%s_busy_after", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s_hold", tag), ieee_packet_out, exp_res);
  endtask

  initial begin
    bit saw_end;
    start     = 1'b0;
    a_operand = '0;
    b_operand = '0;
    operation = op_add;
    arst      = 1'b1;
    #1;
    chk("rst_out", ieee_packet_out, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_end", {31'd0, cmd_end}, 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
    end

    // Abort a division partway through with an asynchronous reset.
    @(negedge clk);
    a_operand = 32'h3F800000;
    b_operand = 32'h40400000;
    operation = op_div;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("abort_out", ieee_packet_out, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_end", {31'd0, cmd_end}, 32'd0);
    saw_end = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cmd_end) saw_end = 1'b1;
    end
    arst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_end || busy) saw_end = 1'b1;
    end
    chk("abort_no_end", {31'd0, saw_end}, 32'd0);
    run_vec("post_rst", op_div, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
